rob_ctrl: RTL and testbench

In-order reorder-buffer controller for the 32-entry speculative temporary register file (73-bit entries).
- Allocates one entry per accepted dispatch at the tail.
- Writes CDB results into the tagged entry.
- Retires completed entries from the head in program order to the architectural register file.
- On a flush, sweeps and clears all occupied entries.
- Sits between issue/dispatch, the CDB and architectural commit. It is the temp file's only writer and reads it through one read port.

---
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_if.sv | 51 +++++
 rtl/rob_ptr.sv | 27 ++
 rtl/rob_ctrl.sv | 153 +++++++++++++++
 tb/tb_rob_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder-buffer controller: geometry, entry field
// offsets within the 73-bit temp-file word, and the controller state encoding.
package rob_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int PCW   = 32;
    localparam int EW    = 73;

    localparam int RD_HI      = 72;
    localparam int RD_LO      = 68;
    localparam int PC_HI      = 67;
    localparam int PC_LO      = 36;
    localparam int TYPE_HI    = 35;
    localparam int TYPE_LO    = 34;
    localparam int DATA_HI    = 33;
    localparam int DATA_LO    = 2;
    localparam int SPEC_VALID = 1;
    localparam int VALID      = 0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/rob_if.sv
// Dispatch, CDB, temp-file and commit signals of the reorder buffer.
// The controller takes the master modport; its environment takes slave.
interface rob_if;
    import rob_pkg::*;

    logic             disp_valid;
    logic             disp_ready;
    logic [4:0]       disp_rd;
    logic [PCW-1:0]   disp_pc;
    logic [1:0]       disp_type;
    logic [AW-1:0]    disp_tag;

    logic             cdb_valid;
    logic [AW-1:0]    cdb_tag;
    logic [DW-1:0]    cdb_data;

    logic [EW-1:0]    tmp_data_in;
    logic [AW-1:0]    tmp_waddr;
    logic             tmp_new_entry;
    logic             tmp_update_entry;
    logic [AW-1:0]    tmp_rd_addr;
    logic [EW-1:0]    tmp_rd_data;

    logic             commit_valid;
    logic             commit_ready;
    logic [4:0]       commit_rd;
    logic [DW-1:0]    commit_data;
    logic [PCW-1:0]   commit_pc;
    logic [1:0]       commit_type;

    modport master (
        input  disp_valid, disp_rd, disp_pc, disp_type,
        output disp_ready, disp_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output tmp_data_in, tmp_waddr, tmp_new_entry, tmp_update_entry, tmp_rd_addr,
        input  tmp_rd_data,
        output commit_valid, commit_rd, commit_data, commit_pc, commit_type,
        input  commit_ready
    );

    modport slave (
        output disp_valid, disp_rd, disp_pc, disp_type,
        input  disp_ready, disp_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  tmp_data_in, tmp_waddr, tmp_new_entry, tmp_update_entry, tmp_rd_addr,
        output tmp_rd_data,
        input  commit_valid, commit_rd, commit_data, commit_pc, commit_type,
        output commit_ready
    );

endinterface

// File: rtl/rob_ptr.sv
// Modulo-2^AW pointer with increment and load; load wins over increment.
module rob_ptr #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] value
);

    logic [AW-1:0] value_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_val;
        end else if (inc) begin
            value_reg <= value_reg + AW'(1);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/rob_ctrl.sv
// In-order reorder-buffer controller driving a single-write-port temp file.
// Optional ROB_STATS_EN builds commit and full-stall counters; otherwise they read 0.
module rob_ctrl
    import rob_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    rob_if.master         bus,
    input  logic          flush,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic [31:0]   stat_commits,
    output logic [31:0]   stat_full_stalls
);

    state_t        state_reg, state_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] head, tail, sweep;
    logic          head_load, tail_load, sweep_load;
    logic [AW-1:0] tail_load_val;
    logic          live, running, disp_fire, commit_fire;
    logic [EW-1:0] head_entry;
    logic [EW-1:0] wdata;
    logic [AW-1:0] waddr;
    logic          new_entry, update_entry;

    assign live       = !reset;
    assign running    = live && (state_reg == RUN);
    assign head_entry = bus.tmp_rd_data;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // CDB owns the single write port whenever it is active, so it blocks dispatch.
    assign bus.disp_ready = running && !full && !bus.cdb_valid && !flush;
    assign bus.disp_tag   = tail;
    assign disp_fire      = bus.disp_valid && bus.disp_ready;

    assign bus.commit_valid = running && !flush && !empty &&
                              head_entry[VALID] && head_entry[SPEC_VALID];
    assign commit_fire      = bus.commit_valid && bus.commit_ready;
    assign bus.commit_rd    = head_entry[RD_HI:RD_LO];
    assign bus.commit_pc    = head_entry[PC_HI:PC_LO];
    assign bus.commit_type  = head_entry[TYPE_HI:TYPE_LO];
    assign bus.commit_data  = head_entry[DATA_HI:DATA_LO];
    assign bus.tmp_rd_addr  = head;

    rob_ptr #(.AW(AW)) u_head (
        .clock(clock), .reset(reset), .inc(commit_fire), .load(head_load),
        .load_val(sweep + AW'(1)), .value(head)
    );
    rob_ptr #(.AW(AW)) u_tail (
        .clock(clock), .reset(reset), .inc(disp_fire), .load(tail_load),
        .load_val(tail_load_val), .value(tail)
    );
    rob_ptr #(.AW(AW)) u_sweep (
        .clock(clock), .reset(reset), .inc(state_reg == FLUSH), .load(sweep_load),
        .load_val(head), .value(sweep)
    );

    // While sweeping, count_reg doubles as the number of entries left to clear.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        head_load     = 1'b0;
        tail_load     = 1'b0;
        tail_load_val = head;
        sweep_load    = 1'b0;
        case (state_reg)
            RUN: begin
                if (flush) begin
                    if (count_reg == '0) begin
                        tail_load = 1'b1;
                    end else begin
                        state_next = FLUSH;
                        sweep_load = 1'b1;
                    end
                end else begin
                    count_next = count_reg + (AW+1)'(disp_fire) - (AW+1)'(commit_fire);
                end
            end
            FLUSH: begin
                count_next = count_reg - (AW+1)'(1);
                if (count_reg == (AW+1)'(1)) begin
                    state_next    = RUN;
                    head_load     = 1'b1;
                    tail_load     = 1'b1;
                    tail_load_val = sweep + AW'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        new_entry    = 1'b0;
        update_entry = 1'b0;
        waddr        = tail;
        wdata        = '0;
        if (live) begin
            if (state_reg == FLUSH) begin
                new_entry = 1'b1;
                waddr     = sweep;
            end else if (bus.cdb_valid) begin
                update_entry              = 1'b1;
                waddr                     = bus.cdb_tag;
                wdata[DATA_HI:DATA_LO]    = bus.cdb_data;
                wdata[SPEC_VALID]         = 1'b1;
            end else if (disp_fire) begin
                new_entry = 1'b1;
                wdata     = {bus.disp_rd, bus.disp_pc, bus.disp_type, 32'd0, 1'b0, 1'b1};
            end
        end
    end

    assign bus.tmp_data_in      = wdata;
    assign bus.tmp_waddr        = waddr;
    assign bus.tmp_new_entry    = new_entry;
    assign bus.tmp_update_entry = update_entry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

`ifdef ROB_STATS_EN
    logic [31:0] commits_reg, stalls_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commits_reg <= '0;
            stalls_reg  <= '0;
        end else begin
            if (commit_fire) commits_reg <= commits_reg + 32'd1;
            if (bus.disp_valid && full) stalls_reg <= stalls_reg + 32'd1;
        end
    end

    assign stat_commits     = commits_reg;
    assign stat_full_stalls = stalls_reg;
`else
    assign stat_commits     = 32'd0;
    assign stat_full_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the in-flight instruction window.
module tb_rob_ctrl;
    import rob_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          empty, full;
    logic [AW:0]   count;
    logic [31:0]   stat_commits, stat_full_stalls;

    rob_if bus ();

    rob_ctrl dut (
        .clock(clock), .reset(reset), .bus(bus), .flush(flush),
        .empty(empty), .full(full), .count(count),
        .stat_commits(stat_commits), .stat_full_stalls(stat_full_stalls)
    );

    always #5 clock = ~clock;

    // Temp register file behaviour: full write on new_entry, spec fields only on update.
    logic [EW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (bus.tmp_new_entry) mem[bus.tmp_waddr] <= bus.tmp_data_in;
        else if (bus.tmp_update_entry) mem[bus.tmp_waddr][33:1] <= bus.tmp_data_in[33:1];
    end
    assign bus.tmp_rd_data = mem[bus.tmp_rd_addr];

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  ty;
        logic [31:0] data;
        bit          done;
    } ent_t;

    ent_t q[$];
    int   m_head, m_flush_left, m_sweep, m_commits, m_stalls;
    int   checks = 0;
    int   failures = 0;

    task automatic idle();
        bus.disp_valid = 0; bus.disp_rd = '0; bus.disp_pc = '0; bus.disp_type = '0;
        bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.commit_ready = 0; flush = 0;
    endtask

    task automatic tick();
        int sz = q.size();
        int tl = (m_head + sz) % DEPTH;
        bit cfire = 0;
        bit dfire;
        ent_t e;
        if (m_flush_left == 0 && bus.disp_valid && sz == DEPTH) m_stalls++;
        if (m_flush_left > 0) begin
            m_sweep = (m_sweep + 1) % DEPTH;
            m_flush_left--;
            if (m_flush_left == 0) m_head = m_sweep;
        end else if (flush) begin
            if (sz > 0) begin m_flush_left = sz; m_sweep = m_head; end
            q.delete();
        end else begin
            if (sz > 0) cfire = bus.commit_ready && q[0].done;
            dfire = bus.disp_valid && sz < DEPTH && !bus.cdb_valid;
            if (bus.cdb_valid)
                foreach (q[i]) if (q[i].tag == int'(bus.cdb_tag)) begin q[i].done = 1; q[i].data = bus.cdb_data; end
            if (cfire) begin void'(q.pop_front()); m_head = (m_head + 1) % DEPTH; m_commits++; end
            if (dfire) begin
                e.tag = tl; e.rd = bus.disp_rd; e.pc = bus.disp_pc; e.ty = bus.disp_type;
                e.data = '0; e.done = 0;
                q.push_back(e);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        q.delete(); m_head = 0; m_flush_left = 0; m_sweep = 0; m_commits = 0; m_stalls = 0;
        @(posedge clock); #1;
        reset = 0;
    endtask

    task automatic dispatch_one(input logic [4:0] rd, input logic [31:0] pc, input logic [1:0] ty);
        idle();
        bus.disp_valid = 1; bus.disp_rd = rd; bus.disp_pc = pc; bus.disp_type = ty;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        bus.disp_valid = 1; bus.cdb_valid = 1; bus.commit_ready = 1;
        #1;
        checks++; if (bus.disp_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.disp_ready); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (bus.tmp_update_entry !== 1'b0 || bus.tmp_new_entry !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%0b%0b exp=00", bus.tmp_new_entry, bus.tmp_update_entry); end
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%0b exp=0", bus.commit_valid); end
        do_reset();
    endtask

    task automatic test_dispatch_commit();
        logic [EW-1:0] exp_w;
        idle();
        bus.disp_valid = 1; bus.disp_rd = 5'd3; bus.disp_pc = 32'h100; bus.disp_type = 2'd1;
        #1;
        exp_w = {5'd3, 32'h100, 2'd1, 32'd0, 1'b0, 1'b1};
        checks++; if (bus.disp_ready !== 1'b1) begin failures++; $display("FAIL disp_ready got=%0b exp=1", bus.disp_ready); end
        checks++; if (bus.disp_tag !== 5'd0) begin failures++; $display("FAIL disp_tag got=%0d exp=0", bus.disp_tag); end
        checks++; if (bus.tmp_new_entry !== 1'b1 || bus.tmp_waddr !== 5'd0) begin failures++; $display("FAIL disp_write got=%0b@%0d exp=1@0", bus.tmp_new_entry, bus.tmp_waddr); end
        checks++; if (bus.tmp_data_in !== exp_w) begin failures++; $display("FAIL disp_data got=%h exp=%h", bus.tmp_data_in, exp_w); end
        tick(); idle(); #1;
        checks++; if (count !== 6'd1) begin failures++; $display("FAIL disp_count got=%0d exp=1", count); end
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL disp_commit_valid got=%0b exp=0", bus.commit_valid); end
        bus.cdb_valid = 1; bus.cdb_tag = 5'd0; bus.cdb_data = 32'hDEAD; bus.commit_ready = 1;
        #1;
        exp_w = {39'd0, 32'hDEAD, 1'b1, 1'b0};
        checks++; if (bus.tmp_update_entry !== 1'b1 || bus.tmp_new_entry !== 1'b0) begin failures++; $display("FAIL cdb_strobes got=%0b%0b exp=01", bus.tmp_new_entry, bus.tmp_update_entry); end
        checks++; if (bus.tmp_data_in !== exp_w || bus.tmp_waddr !== 5'd0) begin failures++; $display("FAIL cdb_data got=%h@%0d exp=%h@0", bus.tmp_data_in, bus.tmp_waddr, exp_w); end
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL cdb_no_bypass got=%0b exp=0", bus.commit_valid); end
        tick(); bus.cdb_valid = 0; #1;
        checks++; if (bus.commit_valid !== 1'b1) begin failures++; $display("FAIL commit_valid got=%0b exp=1", bus.commit_valid); end
        checks++; if (bus.commit_rd !== 5'd3 || bus.commit_data !== 32'hDEAD) begin failures++; $display("FAIL commit_fields got=rd%0d/%h exp=rd3/dead", bus.commit_rd, bus.commit_data); end
        checks++; if (bus.commit_pc !== 32'h100 || bus.commit_type !== 2'd1) begin failures++; $display("FAIL commit_pc_type got=%h/%0d exp=100/1", bus.commit_pc, bus.commit_type); end
        tick(); #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL commit_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.disp_valid = 1; bus.disp_rd = 5'($urandom); bus.disp_pc = $urandom; bus.disp_type = 2'($urandom);
            #1;
            checks++; if (bus.disp_tag !== 5'(i) || bus.disp_ready !== 1'b1) begin failures++; $display("FAIL fill_tag got=%0d/%0b exp=%0d/1", bus.disp_tag, bus.disp_ready, i); end
            tick();
        end
        idle(); bus.disp_valid = 1; #1;
        checks++; if (full !== 1'b1 || count !== 6'd32) begin failures++; $display("FAIL full_flag got=%0b/%0d exp=1/32", full, count); end
        checks++; if (bus.disp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.disp_ready); end
        tick();
        idle(); bus.cdb_valid = 1; bus.cdb_tag = 5'd0; bus.cdb_data = $urandom; tick();
        idle(); bus.disp_valid = 1; bus.commit_ready = 1; #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.disp_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=cv%0b/rdy%0b exp=cv1/rdy0", bus.commit_valid, bus.disp_ready); end
        tick();
        idle(); bus.disp_valid = 1; #1;
        checks++; if (count !== 6'd31 || full !== 1'b0) begin failures++; $display("FAIL after_commit got=%0d/%0b exp=31/0", count, full); end
        checks++; if (bus.disp_ready !== 1'b1 || bus.disp_tag !== 5'd0) begin failures++; $display("FAIL wrap_tag got=%0d/%0b exp=0/1", bus.disp_tag, bus.disp_ready); end
        tick(); idle(); #1;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL refull got=%0b exp=1", full); end
    endtask

    task automatic test_disp_cdb_conflict();
        do_reset();
        dispatch_one(5'd1, 32'h10, 2'd0);
        dispatch_one(5'd2, 32'h14, 2'd0);
        bus.disp_valid = 1; bus.cdb_valid = 1; bus.cdb_tag = 5'd1; bus.cdb_data = $urandom;
        #1;
        checks++; if (bus.disp_ready !== 1'b0) begin failures++; $display("FAIL conflict_ready got=%0b exp=0", bus.disp_ready); end
        checks++; if (bus.tmp_update_entry !== 1'b1 || bus.tmp_new_entry !== 1'b0 || bus.tmp_waddr !== 5'd1) begin failures++; $display("FAIL conflict_write got=%0b%0b@%0d exp=01@1", bus.tmp_new_entry, bus.tmp_update_entry, bus.tmp_waddr); end
        tick(); idle(); bus.disp_valid = 1; #1;
        checks++; if (count !== 6'd2 || bus.disp_tag !== 5'd2) begin failures++; $display("FAIL conflict_tail got=%0d/%0d exp=2/2", count, bus.disp_tag); end
        tick(); idle();
    endtask

    task automatic test_out_of_order();
        do_reset();
        dispatch_one(5'd7, 32'h200, 2'd2);
        dispatch_one(5'd9, 32'h204, 2'd3);
        bus.cdb_valid = 1; bus.cdb_tag = 5'd1; bus.cdb_data = 32'h1111; bus.commit_ready = 1;
        tick(); bus.cdb_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_wait cyc=%0d got=%0b exp=0", i, bus.commit_valid); end
            tick();
        end
        bus.cdb_valid = 1; bus.cdb_tag = 5'd0; bus.cdb_data = 32'h2222; tick(); bus.cdb_valid = 0; #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd7 || bus.commit_data !== 32'h2222) begin failures++; $display("FAIL ooo_first got=%0b rd%0d %h exp=1 rd7 2222", bus.commit_valid, bus.commit_rd, bus.commit_data); end
        tick(); #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd9 || bus.commit_data !== 32'h1111) begin failures++; $display("FAIL ooo_second got=%0b rd%0d %h exp=1 rd9 1111", bus.commit_valid, bus.commit_rd, bus.commit_data); end
        tick(); #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ooo_empty got=%0b exp=1", empty); end
        idle();
    endtask

    task automatic test_flush_wrap();
        int n;
        do_reset();
        for (int i = 0; i < 30; i++) dispatch_one(5'($urandom), $urandom, 2'($urandom));
        for (int i = 0; i < 30; i++) begin
            bus.cdb_valid = 1; bus.cdb_tag = 5'(i); bus.cdb_data = $urandom; bus.commit_ready = 1;
            tick();
        end
        idle(); bus.commit_ready = 1; n = 0;
        while (q.size() > 0 && n < 40) begin tick(); n++; end
        idle(); #1;
        checks++; if (empty !== 1'b1 || bus.tmp_rd_addr !== 5'd30) begin failures++; $display("FAIL drain got=%0b@%0d exp=1@30", empty, bus.tmp_rd_addr); end
        for (int i = 0; i < 5; i++) begin
            bus.disp_valid = 1; bus.disp_rd = 5'(i); bus.disp_pc = $urandom; #1;
            checks++; if (bus.disp_tag !== 5'((30 + i) % DEPTH)) begin failures++; $display("FAIL flush_fill got=%0d exp=%0d", bus.disp_tag, (30 + i) % DEPTH); end
            tick();
        end
        idle(); bus.cdb_valid = 1; bus.cdb_tag = 5'd30; tick();
        idle(); flush = 1; bus.disp_valid = 1; bus.commit_ready = 1; #1;
        checks++; if (bus.disp_ready !== 1'b0 || bus.commit_valid !== 1'b0) begin failures++; $display("FAIL flush_cycle got=rdy%0b/cv%0b exp=0/0", bus.disp_ready, bus.commit_valid); end
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.cdb_valid = 1; bus.cdb_tag = 5'($urandom);
            #1;
            checks++; if (bus.tmp_new_entry !== 1'b1 || bus.tmp_update_entry !== 1'b0 || bus.tmp_waddr !== 5'((30 + k) % DEPTH) || bus.tmp_data_in !== '0) begin failures++; $display("FAIL sweep k=%0d got=%0b%0b@%0d exp=10@%0d", k, bus.tmp_new_entry, bus.tmp_update_entry, bus.tmp_waddr, (30 + k) % DEPTH); end
            checks++; if (bus.disp_ready !== 1'b0 || bus.commit_valid !== 1'b0) begin failures++; $display("FAIL sweep_hs k=%0d got=%0b/%0b exp=0/0", k, bus.disp_ready, bus.commit_valid); end
            tick();
            flush = 0;
        end
        idle(); bus.disp_valid = 1; #1;
        checks++; if (count !== 6'd0 || empty !== 1'b1 || bus.tmp_rd_addr !== 5'd3) begin failures++; $display("FAIL flush_end got=%0d/%0b@%0d exp=0/1@3", count, empty, bus.tmp_rd_addr); end
        checks++; if (bus.disp_ready !== 1'b1 || bus.disp_tag !== 5'd3) begin failures++; $display("FAIL flush_tail got=%0b/%0d exp=1/3", bus.disp_ready, bus.disp_tag); end
        tick(); idle();
    endtask

    task automatic test_reset_midflush();
        do_reset();
        for (int i = 0; i < 3; i++) dispatch_one(5'(i), $urandom, 2'd0);
        flush = 1; tick(); flush = 0; #1;
        checks++; if (bus.tmp_new_entry !== 1'b1) begin failures++; $display("FAIL midflush_sweep got=%0b exp=1", bus.tmp_new_entry); end
        reset = 1; #1;
        checks++; if (bus.tmp_new_entry !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin failures++; $display("FAIL midflush_reset got=%0b/%0d/%0b exp=0/0/1", bus.tmp_new_entry, count, empty); end
        do_reset();
        bus.disp_valid = 1; #1;
        checks++; if (bus.disp_ready !== 1'b1 || bus.disp_tag !== 5'd0) begin failures++; $display("FAIL midflush_run got=%0b/%0d exp=1/0", bus.disp_ready, bus.disp_tag); end
        idle();
    endtask

    task automatic test_random();
        int cand[$];
        bit fl, exp_ready, exp_cv;
        int sz, exp_tail;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            fl = (m_flush_left > 0);
            if (!fl) begin
                bus.disp_valid = ($urandom_range(0, 99) < 60);
                bus.disp_rd = 5'($urandom); bus.disp_pc = $urandom; bus.disp_type = 2'($urandom);
                flush = ($urandom_range(0, 99) < 3);
                cand.delete();
                foreach (q[i]) if (!q[i].done) cand.push_back(q[i].tag);
                if (cand.size() > 0 && $urandom_range(0, 99) < 45) begin
                    bus.cdb_valid = 1;
                    bus.cdb_tag = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                    bus.cdb_data = $urandom;
                end
                bus.commit_ready = ($urandom_range(0, 99) < 70);
            end else begin
                flush = 1'($urandom); bus.cdb_valid = 1'($urandom); bus.cdb_tag = 5'($urandom);
                bus.commit_ready = 1;
            end
            #1;
            sz = q.size();
            exp_tail = (m_head + sz) % DEPTH;
            exp_ready = !fl && sz < DEPTH && !bus.cdb_valid && !flush;
            exp_cv = 0;
            if (!fl && !flush && sz > 0) exp_cv = q[0].done;
            checks++; if (bus.disp_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, bus.disp_ready, exp_ready); end
            checks++; if (bus.commit_valid !== exp_cv) begin failures++; $display("FAIL rnd_cv cyc=%0d got=%0b exp=%0b", cyc, bus.commit_valid, exp_cv); end
            if (!fl) begin
                checks++; if (count !== 6'(sz) || empty !== (sz == 0) || full !== (sz == DEPTH)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%0b/%0b exp=%0d", cyc, count, empty, full, sz); end
                checks++; if (bus.tmp_rd_addr !== 5'(m_head)) begin failures++; $display("FAIL rnd_head cyc=%0d got=%0d exp=%0d", cyc, bus.tmp_rd_addr, m_head); end
                checks++; if (bus.tmp_update_entry !== bus.cdb_valid || bus.tmp_new_entry !== (exp_ready && bus.disp_valid)) begin failures++; $display("FAIL rnd_strobe cyc=%0d got=%0b%0b", cyc, bus.tmp_new_entry, bus.tmp_update_entry); end
                if (exp_ready) begin
                    checks++; if (bus.disp_tag !== 5'(exp_tail)) begin failures++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", cyc, bus.disp_tag, exp_tail); end
                end
                if (exp_cv) begin
                    checks++; if (bus.commit_rd !== q[0].rd || bus.commit_data !== q[0].data || bus.commit_pc !== q[0].pc || bus.commit_type !== q[0].ty) begin failures++; $display("FAIL rnd_commit cyc=%0d got=rd%0d %h exp=rd%0d %h", cyc, bus.commit_rd, bus.commit_data, q[0].rd, q[0].data); end
                end
            end else begin
                checks++; if (bus.tmp_new_entry !== 1'b1 || bus.tmp_update_entry !== 1'b0 || bus.tmp_waddr !== 5'(m_sweep)) begin failures++; $display("FAIL rnd_sweep cyc=%0d got=%0b%0b@%0d exp=10@%0d", cyc, bus.tmp_new_entry, bus.tmp_update_entry, bus.tmp_waddr, m_sweep); end
            end
            tick();
        end
        idle(); #1;
`ifdef ROB_STATS_EN
        checks++; if (stat_commits !== 32'(m_commits) || stat_full_stalls !== 32'(m_stalls)) begin failures++; $display("FAIL stats got=%0d/%0d exp=%0d/%0d", stat_commits, stat_full_stalls, m_commits, m_stalls); end
`else
        checks++; if (stat_commits !== 32'd0 || stat_full_stalls !== 32'd0) begin failures++; $display("FAIL stats got=%0d/%0d exp=0/0", stat_commits, stat_full_stalls); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = '0;
        reset = 1;
        idle();
        #2;
        test_reset();
        test_dispatch_commit();
        test_full_wrap();
        test_disp_cdb_conflict();
        test_out_of_order();
        test_flush_wrap();
        test_reset_midflush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
